// File: rtl/cu_dispatcher_if.sv
// Host/CU-array bundle for cu_dispatcher: launch handshake, status and per-CU control lanes.
// busy_cycles exists only when CU_DISPATCH_PERF_EN is defined.
interface cu_dispatcher_if #(
  parameter int NUM_CUS          = 2,
  parameter int NUM_THREADS      = 4,
  parameter int THREAD_CNT_WIDTH = 8,
  parameter int BLOCK_IDX_WIDTH  = 8
);
  localparam int AT_WIDTH = $clog2(NUM_THREADS + 1);

  logic                                 start;
  logic [THREAD_CNT_WIDTH-1:0]          thread_count;
  logic                                 busy;
  logic                                 done;
  logic [NUM_CUS-1:0]                   cu_reset;
  logic [NUM_CUS-1:0]                   cu_enable;
  logic [NUM_CUS-1:0]                   cu_complete;
  logic [NUM_CUS*BLOCK_IDX_WIDTH-1:0]   cu_block_idx;
  logic [NUM_CUS*AT_WIDTH-1:0]          cu_active_threads;
`ifdef CU_DISPATCH_PERF_EN
  logic [15:0]                          busy_cycles;

  modport slave (
    input  start, thread_count, cu_complete,
    output busy, done, cu_reset, cu_enable, cu_block_idx, cu_active_threads, busy_cycles
  );
  modport master (
    output start, thread_count, cu_complete,
    input  busy, done, cu_reset, cu_enable, cu_block_idx, cu_active_threads, busy_cycles
  );
`else
  modport slave (
    input  start, thread_count, cu_complete,
    output busy, done, cu_reset, cu_enable, cu_block_idx, cu_active_threads
  );
  modport master (
    output start, thread_count, cu_complete,
    input  busy, done, cu_reset, cu_enable, cu_block_idx, cu_active_threads
  );
`endif
endinterface

// File: rtl/cu_dispatcher.sv
// Splits a kernel into NUM_THREADS-wide blocks and hands them to NUM_CUS compute units.
// Optional busy-cycle counter enabled by defining CU_DISPATCH_PERF_EN.
//
// state       | meaning
// ST_IDLE     | no kernel since reset
// ST_DISPATCH | kernel in flight, blocks being issued / completing (busy)
// ST_DONE     | all blocks completed (done held)
// slot FREE   | CU idle, may take a block
// slot LOAD   | cu_reset pulsed, block index / active threads presented
// slot RUN    | cu_enable high until cu_complete seen
module cu_dispatcher #(
  parameter int NUM_CUS          = 2,
  parameter int NUM_THREADS      = 4,
  parameter int THREAD_CNT_WIDTH = 8,
  parameter int BLOCK_IDX_WIDTH  = 8,
  localparam int AT_WIDTH        = $clog2(NUM_THREADS + 1)
) (
  input logic           clk,
  input logic           reset,
  cu_dispatcher_if.slave bus
);
  localparam int CNT_W = THREAD_CNT_WIDTH + 1;
  localparam int LOG_T = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_DISPATCH = 2'b01, ST_DONE = 2'b10} state_t;
  typedef enum logic [1:0] {SLOT_FREE = 2'b00, SLOT_LOAD = 2'b01, SLOT_RUN = 2'b10} slot_t;

  state_t state, state_nxt;
  slot_t  slot_st [NUM_CUS];

  logic [CNT_W-1:0]    total_blocks, blocks_dispatched, blocks_done, done_inc, total_calc;
  logic [AT_WIDTH-1:0] rem_r, load_active;
  logic [NUM_CUS-1:0]  grant, comp_vec, cu_reset_r, cu_enable_r;
  logic [NUM_CUS*BLOCK_IDX_WIDTH-1:0] block_idx_r;
  logic [NUM_CUS*AT_WIDTH-1:0]        active_r;
  logic start_accept, dispatch_ok, found, busy, done;

  assign start_accept = bus.start && (state == ST_IDLE || state == ST_DONE);
  assign total_calc   = ({1'b0, bus.thread_count} + CNT_W'(NUM_THREADS - 1)) >> LOG_T;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start)
          state_nxt = (bus.thread_count == '0) ? ST_DONE : ST_DISPATCH;
      end
      ST_DISPATCH: begin
        if (blocks_done == total_blocks) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_DISPATCH);
    done = (state == ST_DONE);
  end

  // Lowest-index free slot wins; only one block is issued per cycle.
  assign dispatch_ok = (state == ST_DISPATCH) && (blocks_dispatched < total_blocks);
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CUS; i++) begin
      if (!found && slot_st[i] == SLOT_FREE) begin
        grant[i] = dispatch_ok;
        found    = 1'b1;
      end
    end
  end

  // Completion only counts while enable is high, which masks the stale level during LOAD.
  assign comp_vec = bus.cu_complete & cu_enable_r;
  always_comb begin
    done_inc = '0;
    for (int i = 0; i < NUM_CUS; i++) done_inc = done_inc + CNT_W'(comp_vec[i]);
  end

  assign load_active = (blocks_dispatched == total_blocks - 1'b1 && rem_r != '0)
                       ? rem_r : AT_WIDTH'(NUM_THREADS);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      total_blocks      <= '0;
      blocks_dispatched <= '0;
      blocks_done       <= '0;
      rem_r             <= '0;
      cu_reset_r        <= '0;
      cu_enable_r       <= '0;
      block_idx_r       <= '0;
      active_r          <= '0;
      for (int i = 0; i < NUM_CUS; i++) slot_st[i] <= SLOT_FREE;
    end else begin
      if (start_accept) begin
        total_blocks      <= total_calc;
        rem_r             <= AT_WIDTH'(bus.thread_count & THREAD_CNT_WIDTH'(NUM_THREADS - 1));
        blocks_dispatched <= '0;
        blocks_done       <= '0;
      end else begin
        blocks_done <= blocks_done + done_inc;
        if (|grant) blocks_dispatched <= blocks_dispatched + 1'b1;
      end
      for (int i = 0; i < NUM_CUS; i++) begin
        case (slot_st[i])
          SLOT_FREE: begin
            if (grant[i]) begin
              slot_st[i]    <= SLOT_LOAD;
              cu_reset_r[i] <= 1'b1;
              block_idx_r[i*BLOCK_IDX_WIDTH +: BLOCK_IDX_WIDTH] <= BLOCK_IDX_WIDTH'(blocks_dispatched);
              active_r[i*AT_WIDTH +: AT_WIDTH] <= load_active;
            end
          end
          SLOT_LOAD: begin
            slot_st[i]     <= SLOT_RUN;
            cu_reset_r[i]  <= 1'b0;
            cu_enable_r[i] <= 1'b1;
          end
          SLOT_RUN: begin
            if (comp_vec[i]) begin
              slot_st[i]     <= SLOT_FREE;
              cu_enable_r[i] <= 1'b0;
            end
          end
          default: slot_st[i] <= SLOT_FREE;
        endcase
      end
    end
  end

  assign bus.busy              = busy;
  assign bus.done              = done;
  assign bus.cu_reset          = cu_reset_r;
  assign bus.cu_enable         = cu_enable_r;
  assign bus.cu_block_idx      = block_idx_r;
  assign bus.cu_active_threads = active_r;

`ifdef CU_DISPATCH_PERF_EN
  logic [15:0] busy_cycles_r;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                    busy_cycles_r <= '0;
    else if (start_accept)                         busy_cycles_r <= '0;
    else if (busy && busy_cycles_r != 16'hFFFF)    busy_cycles_r <= busy_cycles_r + 16'd1;
  end
  assign bus.busy_cycles = busy_cycles_r;
`endif
endmodule

// File: tb/tb_cu_dispatcher.sv
// Directed bench for cu_dispatcher with NUM_CUS=2, NUM_THREADS=4; inputs change and outputs are sampled on negedge.
module tb_cu_dispatcher;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  cu_dispatcher_if #(.NUM_CUS(2), .NUM_THREADS(4), .THREAD_CNT_WIDTH(8), .BLOCK_IDX_WIDTH(8)) bus ();

  cu_dispatcher #(.NUM_CUS(2), .NUM_THREADS(4), .THREAD_CNT_WIDTH(8), .BLOCK_IDX_WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic launch(input logic [7:0] tc);
    bus.thread_count = tc;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  function automatic logic [7:0] idx(input int i);
    return bus.cu_block_idx[i*8 +: 8];
  endfunction

  function automatic logic [2:0] act(input int i);
    return bus.cu_active_threads[i*3 +: 3];
  endfunction

  initial begin
    bus.start = 1'b0;
    bus.thread_count = '0;
    bus.cu_complete = '0;
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cu_reset", bus.cu_reset, 0);
    check("rst_enable", bus.cu_enable, 0);
    check("rst_idx", bus.cu_block_idx, 0);
    check("rst_active", bus.cu_active_threads, 0);
    step(2);
    reset = 1'b1;
    step();

    // 8 threads: two full blocks, CU0 completes first
    launch(8);
    check("t1_busy", bus.busy, 1);
    check("t1_no_reset_yet", bus.cu_reset, 2'b00);
    step();
    check("t1_load0", bus.cu_reset, 2'b01);
    check("t1_idx0", idx(0), 0);
    check("t1_act0", act(0), 4);
    step();
    check("t1_en0", bus.cu_enable, 2'b01);
    check("t1_load1", bus.cu_reset, 2'b10);
    check("t1_idx1", idx(1), 1);
    check("t1_act1", act(1), 4);
    step();
    check("t1_en_both", bus.cu_enable, 2'b11);
    bus.cu_complete = 2'b01;
    step();
    bus.cu_complete = 2'b00;
    check("t1_en_after0", bus.cu_enable, 2'b10);
    check("t1_done_early", bus.done, 0);
    step();
    bus.cu_complete = 2'b10;
    step();
    bus.cu_complete = 2'b00;
    check("t1_en_after1", bus.cu_enable, 2'b00);
    check("t1_done_lag", bus.done, 0);
    step();
    check("t1_done", bus.done, 1);
    check("t1_busy_low", bus.busy, 0);

    // 10 threads: CU1 completes first and gets the partial block; stale complete held through LOAD
    launch(10);
    check("t2_done_clr", bus.done, 0);
    step(3);
    check("t2_en_both", bus.cu_enable, 2'b11);
    bus.cu_complete = 2'b10;
    step();
    check("t2_no_same_cycle", bus.cu_reset, 2'b00);
    check("t2_en1_drop", bus.cu_enable, 2'b01);
    step();
    bus.cu_complete = 2'b00;
    check("t2_reload1", bus.cu_reset, 2'b10);
    check("t2_idx1", idx(1), 2);
    check("t2_act1", act(1), 2);
    check("t2_idx0_hold", idx(0), 0);
    step();
    check("t2_en_both2", bus.cu_enable, 2'b11);
    check("t2_not_done", bus.done, 0);
    bus.cu_complete = 2'b11;
    step();
    bus.cu_complete = 2'b00;
    check("t2_both_drop", bus.cu_enable, 2'b00);
    check("t2_done_lag", bus.done, 0);
    step();
    check("t2_done", bus.done, 1);
    check("t2_act1_hold", act(1), 2);
    check("t2_idx1_hold", idx(1), 2);

    // start while busy must be ignored
    launch(8);
    step();
    launch(16);
    check("t5_en0", bus.cu_enable, 2'b01);
    step();
    bus.cu_complete = 2'b11;
    step();
    bus.cu_complete = 2'b00;
    check("t5_drop", bus.cu_enable, 2'b00);
    step();
    check("t5_done", bus.done, 1);
    check("t5_no_reload", bus.cu_reset, 2'b00);

    // zero-thread kernel after a fresh reset
    reset = 1'b0;
    step();
    reset = 1'b1;
    step();
    launch(0);
    check("t3_done", bus.done, 1);
    check("t3_busy", bus.busy, 0);
    step(2);
    check("t3_no_reset", bus.cu_reset, 2'b00);
    check("t3_no_enable", bus.cu_enable, 2'b00);
    check("t3_busy_stay", bus.busy, 0);

    // reset mid-RUN, then a single-block kernel
    launch(8);
    step(3);
    check("t6_en_both", bus.cu_enable, 2'b11);
    reset = 1'b0;
    #1;
    check("t6_async_en", bus.cu_enable, 2'b00);
    check("t6_async_busy", bus.busy, 0);
    step();
    reset = 1'b1;
    step();
    launch(4);
    check("t6_busy", bus.busy, 1);
    step();
    check("t6_load0", bus.cu_reset, 2'b01);
    check("t6_act0", act(0), 4);
    check("t6_idx0", idx(0), 0);
    step();
    check("t6_en0", bus.cu_enable, 2'b01);
    step();
    check("t6_no_cu1", bus.cu_reset, 2'b00);
    bus.cu_complete = 2'b01;
    step();
    bus.cu_complete = 2'b00;
    step();
    check("t6_done", bus.done, 1);

`ifdef CU_DISPATCH_PERF_EN
    // completions sampled 5 edges after CU0 enable and 7 edges after CU0 enable: busy high 10 cycles
    launch(8);
    check("pf_clear", bus.busy_cycles, 0);
    step(6);
    bus.cu_complete = 2'b01;
    step();
    bus.cu_complete = 2'b00;
    step();
    bus.cu_complete = 2'b10;
    step();
    bus.cu_complete = 2'b00;
    step();
    check("pf_done", bus.done, 1);
    check("pf_count", bus.busy_cycles, 10);
    step(3);
    check("pf_hold", bus.busy_cycles, 10);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
